// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters, plus the
// execute-side misprediction check, table training and saturating statistics.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_valid,
    input  logic [31:0]       ex_pc,
    input  logic [1:0]        ex_pc_sel,
    input  logic              ex_is_branch,
    input  logic [31:0]       ex_target,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mp_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [STAT_W-1:0] STAT_ONE = 1;

    logic              valid_mem  [ENTRIES];
    logic [TAG_W-1:0]  tag_mem    [ENTRIES];
    logic [31:0]       target_mem [ENTRIES];
    logic [1:0]        ctr_mem    [ENTRIES];

    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  ex_idx;
    logic              if_hit;
    logic              ex_hit;
    logic              actual_taken;
    logic              write_en;
    logic              br_inc;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign if_hit = valid_mem[if_idx] && (tag_mem[if_idx] == if_pc[31:IDX_W+2]);
    assign ex_hit = valid_mem[ex_idx] && (tag_mem[ex_idx] == ex_pc[31:IDX_W+2]);

    assign actual_taken = ex_valid && (ex_pc_sel == 2'b10 ||
                                       (ex_pc_sel == 2'b01 && ex_is_branch));
    assign write_en = !rst && ex_valid &&
                      (ex_pc_sel == 2'b10 || (ex_pc_sel == 2'b01 && ex_is_branch));
    assign br_inc = ex_valid && (ex_pc_sel == 2'b01 || ex_pc_sel == 2'b10);

    // Reset gates the visible prediction and redirect so nothing stale escapes.
    always_comb begin
        pred_taken  = !rst && if_hit && ctr_mem[if_idx][1];
        pred_target = pred_taken ? target_mem[if_idx] : if_pc + 32'd4;
        mispredict  = !rst && ex_valid &&
                      (actual_taken != ex_pred_taken ||
                       (actual_taken && ex_target != ex_pred_target));
        redirect_pc = (!rst && actual_taken) ? ex_target : ex_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_mem[i] <= 1'b0;
                ctr_mem[i]   <= 2'b00;
            end
        end else if (ex_valid) begin
            case (ex_pc_sel)
                2'b01: begin
                    if (ex_hit) begin
                        if (ex_is_branch && ctr_mem[ex_idx] != 2'b11)
                            ctr_mem[ex_idx] <= ctr_mem[ex_idx] + 2'd1;
                        else if (!ex_is_branch && ctr_mem[ex_idx] != 2'b00)
                            ctr_mem[ex_idx] <= ctr_mem[ex_idx] - 2'd1;
                    end else if (ex_is_branch) begin
                        valid_mem[ex_idx] <= 1'b1;
                        ctr_mem[ex_idx]   <= 2'b10;
                    end
                end
                2'b10: begin
                    valid_mem[ex_idx] <= 1'b1;
                    ctr_mem[ex_idx]   <= 2'b11;
                end
                default: begin
                    // A sequential instruction hitting the table means a stale alias.
                    if (ex_hit)
                        valid_mem[ex_idx] <= 1'b0;
                end
            endcase
        end
    end

    // Tag and target carry no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (write_en) begin
            tag_mem[ex_idx]    <= ex_pc[31:IDX_W+2];
            target_mem[ex_idx] <= ex_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (br_inc && br_count != '1)
                br_count <= br_count + STAT_ONE;
            if (mispredict && mp_count != '1)
                mp_count <= mp_count + STAT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: combinational vector table, then
// hand-written training, aliasing, saturation and reset sequences.
module tb_branch_predictor;

    localparam int STAT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       if_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [1:0]        ex_pc_sel;
    logic              ex_is_branch;
    logic [31:0]       ex_target;
    logic              ex_pred_taken;
    logic [31:0]       ex_pred_target;
    logic              mispredict;
    logic [31:0]       redirect_pc;
    logic [STAT_W-1:0] br_count;
    logic [STAT_W-1:0] mp_count;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [1:0]  sel;
        logic        br;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        exp_mp;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    branch_predictor #(.ENTRIES(16), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc_sel(ex_pc_sel),
        .ex_is_branch(ex_is_branch), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveEx(input logic v, input logic [31:0] pc, input logic [1:0] sel,
                           input logic br, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_pc          = pc;
        ex_pc_sel      = sel;
        ex_is_branch   = br;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    // Drive one EX instruction, check the same-cycle verdict, commit it at the edge.
    task automatic applyStimulus(input string name, input logic v, input logic [31:0] pc,
                                 input logic [1:0] sel, input logic br, input logic [31:0] tgt,
                                 input logic pt, input logic [31:0] ptgt,
                                 input logic exp_mp, input logic [31:0] exp_rd);
        driveEx(v, pc, sel, br, tgt, pt, ptgt);
        #1;
        checkOutput({name, "_mp"}, {31'd0, mispredict}, {31'd0, exp_mp});
        checkOutput({name, "_rd"}, redirect_pc, exp_rd);
        tick();
        ex_valid = 1'b0;
        #1;
    endtask

    task automatic checkLookup(input string name, input logic [31:0] pc,
                               input logic exp_pt, input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        checkOutput({name, "_pt"}, {31'd0, pred_taken}, {31'd0, exp_pt});
        checkOutput({name, "_tgt"}, pred_target, exp_tgt);
    endtask

    task automatic checkStats(input string name, input int exp_br, input int exp_mp);
        checkOutput({name, "_br"}, {28'd0, br_count}, exp_br);
        checkOutput({name, "_mpc"}, {28'd0, mp_count}, exp_mp);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h100, 2'b01, 1'b1, 32'h80,  1'b0, 32'h104, 1'b1, 32'h80};
        vecs[1] = '{1'b1, 32'h100, 2'b01, 1'b0, 32'h80,  1'b0, 32'h104, 1'b0, 32'h104};
        vecs[2] = '{1'b1, 32'h100, 2'b01, 1'b0, 32'h80,  1'b1, 32'h80,  1'b1, 32'h104};
        vecs[3] = '{1'b1, 32'h100, 2'b01, 1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h80};
        vecs[4] = '{1'b1, 32'h100, 2'b01, 1'b1, 32'h80,  1'b1, 32'h90,  1'b1, 32'h80};
        vecs[5] = '{1'b1, 32'h100, 2'b10, 1'b0, 32'h400, 1'b0, 32'h104, 1'b1, 32'h400};
        vecs[6] = '{1'b1, 32'h100, 2'b00, 1'b1, 32'h400, 1'b0, 32'h104, 1'b0, 32'h104};
        vecs[7] = '{1'b1, 32'h100, 2'b11, 1'b1, 32'h400, 1'b1, 32'h400, 1'b1, 32'h104};
        vecs[8] = '{1'b0, 32'h100, 2'b10, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 32'h104};
        vecs[9] = '{1'b1, 32'hFFFF_FFFC, 2'b00, 1'b0, 32'h400, 1'b0, 32'h0, 1'b0, 32'h0};

        rst   = 1'b1;
        if_pc = 32'h100;
        driveEx(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkLookup("reset", 32'h100, 1'b0, 32'h104);
        checkStats("reset", 0, 0);

        // Combinational verdicts only; ex_valid is dropped before each edge.
        for (int i = 0; i < 10; i++) begin
            driveEx(vecs[i].v, vecs[i].pc, vecs[i].sel, vecs[i].br,
                    vecs[i].tgt, vecs[i].pt, vecs[i].ptgt);
            #1;
            checkOutput($sformatf("vec%0d_mp", i), {31'd0, mispredict}, {31'd0, vecs[i].exp_mp});
            checkOutput($sformatf("vec%0d_rd", i), redirect_pc, vecs[i].exp_rd);
            ex_valid = 1'b0;
            tick();
        end
        checkStats("after_vecs", 0, 0);
        checkLookup("after_vecs", 32'h100, 1'b0, 32'h104);

        applyStimulus("s2", 1, 32'h100, 2'b01, 1, 32'h80, 0, 32'h104, 1, 32'h80);
        checkLookup("s2_lk", 32'h100, 1'b1, 32'h80);

        applyStimulus("s3a", 1, 32'h100, 2'b01, 0, 32'h80, 1, 32'h80, 1, 32'h104);
        checkLookup("s3a_lk", 32'h100, 1'b0, 32'h104);
        applyStimulus("s3b", 1, 32'h100, 2'b01, 0, 32'h80, 0, 32'h104, 0, 32'h104);
        checkStats("s3", 3, 2);

        // From ctr=00 a still-valid entry must count up, not reallocate at 10.
        applyStimulus("s4a", 1, 32'h100, 2'b01, 1, 32'h80, 0, 32'h104, 1, 32'h80);
        checkLookup("s4a_lk", 32'h100, 1'b0, 32'h104);
        applyStimulus("s4b", 1, 32'h100, 2'b01, 1, 32'h80, 0, 32'h104, 1, 32'h80);
        checkLookup("s4b_lk", 32'h100, 1'b1, 32'h80);
        applyStimulus("s4c", 1, 32'h100, 2'b01, 1, 32'h80, 1, 32'h80, 0, 32'h80);
        checkLookup("s4c_lk", 32'h100, 1'b1, 32'h80);
        applyStimulus("s4d", 1, 32'h100, 2'b01, 1, 32'h80, 1, 32'h80, 0, 32'h80);
        checkLookup("s4d_lk", 32'h100, 1'b1, 32'h80);
        applyStimulus("s4e", 1, 32'h100, 2'b01, 0, 32'h80, 1, 32'h80, 1, 32'h104);
        checkLookup("s4e_lk", 32'h100, 1'b1, 32'h80);
        checkStats("s4", 8, 5);

        applyStimulus("s5jal", 1, 32'h200, 2'b10, 0, 32'h400, 0, 32'h204, 1, 32'h400);
        checkLookup("s5jal_lk", 32'h200, 1'b1, 32'h400);
        applyStimulus("s5jalr", 1, 32'h200, 2'b10, 0, 32'h500, 1, 32'h400, 1, 32'h500);
        checkLookup("s5jalr_lk", 32'h200, 1'b1, 32'h500);
        checkLookup("s5_evicted", 32'h100, 1'b0, 32'h104);
        checkStats("s5", 10, 7);

        applyStimulus("s6alloc", 1, 32'h100, 2'b01, 1, 32'h80, 0, 32'h104, 1, 32'h80);
        checkLookup("s6_hit", 32'h100, 1'b1, 32'h80);
        checkLookup("s6_alias", 32'h140, 1'b0, 32'h144);

        if_pc = 32'h100;
        driveEx(1, 32'h100, 2'b00, 0, 32'h0, 0, 32'h104);
        #1;
        checkOutput("s6_seq_mp", {31'd0, mispredict}, 32'd0);
        checkOutput("s6_old_pt", {31'd0, pred_taken}, 32'd1);
        checkOutput("s6_old_tgt", pred_target, 32'h80);
        tick();
        ex_valid = 1'b0;
        #1;
        checkLookup("s6_inval", 32'h100, 1'b0, 32'h104);
        checkStats("s6", 11, 8);

        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("sat%0d", i), 1, 32'h304, 2'b10, 0, 32'h600,
                          0, 32'h308, 1, 32'h600);
            if (i == 3)
                checkStats("sat_mid", 15, 12);
        end
        checkStats("sat_end", 15, 15);
        checkLookup("sat_lk", 32'h304, 1'b1, 32'h600);

        // Reset arriving with a taken branch in EX must neither redirect nor train.
        if_pc = 32'h304;
        driveEx(1, 32'h380, 2'b01, 1, 32'h700, 0, 32'h384);
        rst = 1'b1;
        #1;
        checkOutput("rst_mp", {31'd0, mispredict}, 32'd0);
        checkOutput("rst_rd", redirect_pc, 32'h384);
        checkOutput("rst_pt", {31'd0, pred_taken}, 32'd0);
        checkOutput("rst_tgt", pred_target, 32'h308);
        tick();
        rst = 1'b0;
        ex_valid = 1'b0;
        #1;
        checkLookup("post_rst_304", 32'h304, 1'b0, 32'h308);
        checkLookup("post_rst_380", 32'h380, 1'b0, 32'h384);
        checkStats("post_rst", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
